ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary that directly consumes the 16-bit ALU's result and z/v/n outputs.
- Registers the ALU result together with the writeback and memory control travelling with the instruction.
- Holds the architectural condition-flag register.
- Resolves conditional branches against that register, producing a registered one-cycle redirect pulse for fetch.
- Supports pipeline stall (hold) and flush (bubble insert).

Parameters:
- WIDTH, 16, datapath width; must match the ALU width.
- RA_W, 3, register-file address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all MEM-side registers and flags.
- flush  in  1  squash the instruction currently in EX.
- ex_valid  in  1  EX holds a real instruction.
- alu_result  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_v  in  1  ALU overflow flag.
- alu_n  in  1  ALU negative flag.
- ex_set_flags  in  1  this instruction updates the flags.
- ex_br  in  1  this instruction is a conditional branch.
- ex_br_cond  in  3  branch condition code.
- ex_br_target  in  WIDTH  computed branch target.
- ex_wr_en  in  1  register writeback enable.
- ex_wr_reg  in  RA_W  writeback register.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_store_data  in  WIDTH  store data.
- mem_valid  out  1  MEM holds a real instruction.
- mem_result  out  WIDTH  registered ALU result; used as the address for loads and stores.
- mem_wr_en  out  1  registered writeback enable.
- mem_wr_reg  out  RA_W  registered writeback register.
- mem_rd  out  1  registered load strobe.
- mem_wr  out  1  registered store strobe.
- mem_store_data  out  WIDTH  registered store data.
- flag_z  out  1  architectural zero flag.
- flag_v  out  1  architectural overflow flag.
- flag_n  out  1  architectural negative flag.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  WIDTH  redirect address, valid while br_taken is high.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Priority each edge: rst > flush > stall > normal advance.
- Reset: every output is 0, including flags, br_taken, br_target and all data fields.
- Normal advance (no rst, flush or stall):
  - All mem_* outputs take the corresponding ex_* / alu_* values.
  - mem_valid <= ex_valid.
  - Control outputs (mem_wr_en, mem_rd, mem_wr) are ANDed with ex_valid.
  - Latency is 1 cycle.
- Flag update: flags <= {alu_z, alu_v, alu_n} only on a normal-advance edge with ex_valid and ex_set_flags. Otherwise the flags hold.
- Branch resolution:
  - A branch is evaluated combinationally in EX against the current flag register, i.e. the flags from the last flag-setting instruction already past EX.
  - If ex_br and ex_set_flags are both set, the branch uses the old flags; the flags then update.
  - Condition codes:
    - 000 NE: !z
    - 001 EQ: z
    - 010 GT: !z & (n==v)
    - 011 LT: n!=v
    - 100 GE: n==v
    - 101 LE: z | (n!=v)
    - 110 OV: v
    - 111 AL: 1
- Branch outputs: on normal advance, br_taken <= ex_valid & ex_br & cond, and br_target <= ex_br_target.
- Stall:
  - All mem_* outputs, flags and br_target hold.
  - br_taken is forced to 0 on every stalled edge, so a redirect is never repeated.
- Flush:
  - mem_valid, mem_wr_en, mem_rd, mem_wr and br_taken <= 0.
  - mem_result, mem_store_data, mem_wr_reg and br_target <= 0.
  - Flags unchanged. A flushed instruction never sets flags or redirects.
- Stall and flush together: flush wins.
- ex_valid=0 on normal advance: inserts a bubble. Data fields may still capture inputs, but all control and br_taken are 0, and flags are unchanged.
- Reset mid-stall or mid-branch: the next edge zeroes everything, and no pending redirect survives.
- No arithmetic in this block. Width is passed through unchanged.

Test Plan:
- Reset: hold rst 2 cycles with all inputs at 1 -> every output 0. Release -> outputs follow inputs after 1 cycle.
- Flag capture: ex_valid=1, set_flags=1, alu_result=0x8000, z=0 v=1 n=1 -> next cycle mem_result=0x8000, flags z0 v1 n1. The following instruction with set_flags=0 leaves the flags unchanged.
- Branch: flags z=1 from a prior op; ex_br=1, cond=001, target=0x0040 -> br_taken=1 for exactly 1 cycle, br_target=0x0040. The same stimulus with cond=000 -> br_taken stays 0.
- Signed compare: flags n=1, v=1, z=0 -> GT (010) taken, LT (011) not taken, GE (100) taken, LE (101) not taken.
- Stall during a taken branch: stall asserted the cycle after br_taken is high for 3 cycles -> br_taken drops to 0 while mem_result and control hold their values for all 3 cycles.
- Flush with simultaneous stall: load with valid=1, set_flags=1, cond=111 branch -> mem_valid=0, mem_rd=0, br_taken=0, flags unchanged.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// ---------------------------------------------------------------------------
// ex_mem_if
// Signal bundle between the EX stage (plus its ALU) and the EX/MEM boundary
// register block. Clock and reset are not carried here.
//
//   Pipeline control : stall, flush
//   EX side (in)     : ex_valid, alu_result, alu_z/v/n, ex_set_flags, ex_br,
//                      ex_br_cond, ex_br_target, ex_wr_en, ex_wr_reg,
//                      ex_mem_rd, ex_mem_wr, ex_store_data
//   MEM side (out)   : mem_valid, mem_result, mem_wr_en, mem_wr_reg, mem_rd,
//                      mem_wr, mem_store_data
//   Flags (out)      : flag_z, flag_v, flag_n
//   Redirect (out)   : br_taken, br_target
//
// The master modport is the driver of EX-side signals (upstream pipeline or
// testbench). The slave modport belongs to ex_mem_stage.
// ---------------------------------------------------------------------------
interface ex_mem_if #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) ();
    logic             stall;
    logic             flush;

    logic             ex_valid;
    logic [WIDTH-1:0] alu_result;
    logic             alu_z;
    logic             alu_v;
    logic             alu_n;
    logic             ex_set_flags;
    logic             ex_br;
    logic [2:0]       ex_br_cond;
    logic [WIDTH-1:0] ex_br_target;
    logic             ex_wr_en;
    logic [RA_W-1:0]  ex_wr_reg;
    logic             ex_mem_rd;
    logic             ex_mem_wr;
    logic [WIDTH-1:0] ex_store_data;

    logic             mem_valid;
    logic [WIDTH-1:0] mem_result;
    logic             mem_wr_en;
    logic [RA_W-1:0]  mem_wr_reg;
    logic             mem_rd;
    logic             mem_wr;
    logic [WIDTH-1:0] mem_store_data;

    logic             flag_z;
    logic             flag_v;
    logic             flag_n;

    logic             br_taken;
    logic [WIDTH-1:0] br_target;

    modport master (
        output stall, flush,
        output ex_valid, alu_result, alu_z, alu_v, alu_n, ex_set_flags,
        output ex_br, ex_br_cond, ex_br_target, ex_wr_en, ex_wr_reg,
        output ex_mem_rd, ex_mem_wr, ex_store_data,
        input  mem_valid, mem_result, mem_wr_en, mem_wr_reg, mem_rd, mem_wr,
        input  mem_store_data, flag_z, flag_v, flag_n, br_taken, br_target
    );

    modport slave (
        input  stall, flush,
        input  ex_valid, alu_result, alu_z, alu_v, alu_n, ex_set_flags,
        input  ex_br, ex_br_cond, ex_br_target, ex_wr_en, ex_wr_reg,
        input  ex_mem_rd, ex_mem_wr, ex_store_data,
        output mem_valid, mem_result, mem_wr_en, mem_wr_reg, mem_rd, mem_wr,
        output mem_store_data, flag_z, flag_v, flag_n, br_taken, br_target
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline boundary. Registers the ALU result with the writeback and
// memory controls of the instruction, owns the architectural z/v/n flag
// register, and resolves conditional branches against that register into a
// registered one-cycle redirect pulse for fetch.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset; zeroes every output
//   bus  - ex_mem_if.slave: stall/flush, EX-side inputs, MEM-side outputs,
//          flags and redirect (see ex_mem_if for the full list)
//
// Edge priority: rst > flush > stall > normal advance.
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input  logic     clk,
    input  logic     rst,
    ex_mem_if.slave  bus
);

    // Branch condition codes
    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic             wr_en;
        logic [RA_W-1:0]  wr_reg;
        logic             rd;
        logic             wr;
        logic [WIDTH-1:0] sdata;
    } mem_reg_t;

    mem_reg_t         pipe_q,      pipe_d;
    logic [2:0]       flags_q,     flags_d;     // {z, v, n}
    logic             br_taken_q,  br_taken_d;
    logic [WIDTH-1:0] br_target_q, br_target_d;

    logic fz, fv, fn;
    logic cond_met;

    assign fz = flags_q[2];
    assign fv = flags_q[1];
    assign fn = flags_q[0];

    // Evaluated against the registered flags, so a branch that also sets
    // flags sees the value from before its own update.
    always_comb begin
        unique case (bus.ex_br_cond)
            CC_NE:   cond_met = !fz;
            CC_EQ:   cond_met = fz;
            CC_GT:   cond_met = !fz && (fn == fv);
            CC_LT:   cond_met = (fn != fv);
            CC_GE:   cond_met = (fn == fv);
            CC_LE:   cond_met = fz || (fn != fv);
            CC_OV:   cond_met = fv;
            default: cond_met = 1'b1;   // AL
        endcase
    end

    always_comb begin
        pipe_d      = pipe_q;
        flags_d     = flags_q;
        br_taken_d  = 1'b0;             // pulse: only a normal advance raises it
        br_target_d = br_target_q;

        if (bus.flush) begin
            // Bubble with zeroed data; flags are architectural and survive.
            pipe_d      = '0;
            br_target_d = '0;
        end else if (bus.stall) begin
            // Hold everything; br_taken already defaults low so a held
            // redirect is never replayed.
        end else begin
            pipe_d.valid  = bus.ex_valid;
            pipe_d.result = bus.alu_result;
            pipe_d.wr_en  = bus.ex_wr_en  & bus.ex_valid;
            pipe_d.wr_reg = bus.ex_wr_reg;
            pipe_d.rd     = bus.ex_mem_rd & bus.ex_valid;
            pipe_d.wr     = bus.ex_mem_wr & bus.ex_valid;
            pipe_d.sdata  = bus.ex_store_data;

            if (bus.ex_valid && bus.ex_set_flags)
                flags_d = {bus.alu_z, bus.alu_v, bus.alu_n};

            br_taken_d  = bus.ex_valid & bus.ex_br & cond_met;
            br_target_d = bus.ex_br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q      <= '0;
            flags_q     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign bus.mem_valid      = pipe_q.valid;
    assign bus.mem_result     = pipe_q.result;
    assign bus.mem_wr_en      = pipe_q.wr_en;
    assign bus.mem_wr_reg     = pipe_q.wr_reg;
    assign bus.mem_rd         = pipe_q.rd;
    assign bus.mem_wr         = pipe_q.wr;
    assign bus.mem_store_data = pipe_q.sdata;
    assign bus.flag_z         = flags_q[2];
    assign bus.flag_v         = flags_q[1];
    assign bus.flag_n         = flags_q[0];
    assign bus.br_taken       = br_taken_q;
    assign bus.br_target      = br_target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed vectors with hand-computed expectations for ex_mem_stage.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    ex_mem_if #(.WIDTH(16), .RA_W(3)) bus ();

    ex_mem_stage #(.WIDTH(16), .RA_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.alu_result    = '0;
        bus.alu_z         = 1'b0;
        bus.alu_v         = 1'b0;
        bus.alu_n         = 1'b0;
        bus.ex_set_flags  = 1'b0;
        bus.ex_br         = 1'b0;
        bus.ex_br_cond    = 3'd0;
        bus.ex_br_target  = '0;
        bus.ex_wr_en      = 1'b0;
        bus.ex_wr_reg     = '0;
        bus.ex_mem_rd     = 1'b0;
        bus.ex_mem_wr     = 1'b0;
        bus.ex_store_data = '0;
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic v, input logic n);
        chk({tag, ".flags"}, {29'd0, bus.flag_z, bus.flag_v, bus.flag_n}, {29'd0, z, v, n});
    endtask

    // Issue a valid branch (no flag update) and check the redirect pulse.
    task automatic br_case(input string tag, input logic [2:0] cond,
                           input logic [15:0] tgt, input logic exp_taken);
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = cond;
        bus.ex_br_target = tgt;
        tick();
        chk({tag, ".br_taken"},  {31'd0, bus.br_taken}, {31'd0, exp_taken});
        chk({tag, ".br_target"}, {16'd0, bus.br_target}, {16'd0, tgt});
    endtask

    initial begin
        // ---- reset with every input high ----
        rst = 1'b1;
        bus.stall         = 1'b1;
        bus.flush         = 1'b1;
        bus.ex_valid      = 1'b1;
        bus.alu_result    = 16'hFFFF;
        bus.alu_z         = 1'b1;
        bus.alu_v         = 1'b1;
        bus.alu_n         = 1'b1;
        bus.ex_set_flags  = 1'b1;
        bus.ex_br         = 1'b1;
        bus.ex_br_cond    = 3'b111;
        bus.ex_br_target  = 16'hFFFF;
        bus.ex_wr_en      = 1'b1;
        bus.ex_wr_reg     = 3'b111;
        bus.ex_mem_rd     = 1'b1;
        bus.ex_mem_wr     = 1'b1;
        bus.ex_store_data = 16'hFFFF;
        tick();
        tick();
        chk("rst.mem_valid",  {31'd0, bus.mem_valid}, 32'd0);
        chk("rst.mem_result", {16'd0, bus.mem_result}, 32'd0);
        chk("rst.ctrl",       {29'd0, bus.mem_wr_en, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("rst.wr_reg",     {29'd0, bus.mem_wr_reg}, 32'd0);
        chk("rst.store_data", {16'd0, bus.mem_store_data}, 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.br_taken",   {31'd0, bus.br_taken}, 32'd0);
        chk("rst.br_target",  {16'd0, bus.br_target}, 32'd0);

        // ---- release: flag-setting load, 0x8000 with z0 v1 n1 ----
        rst = 1'b0;
        idle();
        bus.ex_valid      = 1'b1;
        bus.ex_set_flags  = 1'b1;
        bus.alu_result    = 16'h8000;
        bus.alu_v         = 1'b1;
        bus.alu_n         = 1'b1;
        bus.ex_wr_en      = 1'b1;
        bus.ex_wr_reg     = 3'd5;
        bus.ex_mem_rd     = 1'b1;
        bus.ex_store_data = 16'h1234;
        tick();
        chk("cap.mem_valid",  {31'd0, bus.mem_valid}, 32'd1);
        chk("cap.mem_result", {16'd0, bus.mem_result}, 32'h8000);
        chk("cap.ctrl",       {29'd0, bus.mem_wr_en, bus.mem_rd, bus.mem_wr}, 32'b110);
        chk("cap.wr_reg",     {29'd0, bus.mem_wr_reg}, 32'd5);
        chk("cap.store_data", {16'd0, bus.mem_store_data}, 32'h1234);
        chk_flags("cap", 1'b0, 1'b1, 1'b1);
        chk("cap.br_taken",   {31'd0, bus.br_taken}, 32'd0);

        // ---- store, no flag update: flags must hold ----
        idle();
        bus.ex_valid   = 1'b1;
        bus.alu_result = 16'h0001;
        bus.alu_z      = 1'b1;
        bus.ex_mem_wr  = 1'b1;
        tick();
        chk("nosf.mem_result", {16'd0, bus.mem_result}, 32'h0001);
        chk("nosf.ctrl",       {29'd0, bus.mem_wr_en, bus.mem_rd, bus.mem_wr}, 32'b001);
        chk_flags("nosf", 1'b0, 1'b1, 1'b1);

        // ---- signed compares with z0 v1 n1 ----
        br_case("gt", 3'b010, 16'h0100, 1'b1);
        br_case("lt", 3'b011, 16'h0104, 1'b0);
        br_case("ge", 3'b100, 16'h0108, 1'b1);
        br_case("le", 3'b101, 16'h010C, 1'b0);
        br_case("ov", 3'b110, 16'h0110, 1'b1);

        // ---- set z=1, then EQ taken for exactly one cycle, NE not taken ----
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_set_flags = 1'b1;
        bus.alu_z        = 1'b1;
        tick();
        chk_flags("setz", 1'b1, 1'b0, 1'b0);
        br_case("eq", 3'b001, 16'h0040, 1'b1);
        idle();
        bus.ex_valid = 1'b1;
        tick();
        chk("eq.pulse_end", {31'd0, bus.br_taken}, 32'd0);
        br_case("ne", 3'b000, 16'h0040, 1'b0);

        // ---- branch that also sets flags uses the old z=1 ----
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b001;
        bus.ex_br_target = 16'h0080;
        bus.ex_set_flags = 1'b1;
        tick();
        chk("brsf.br_taken", {31'd0, bus.br_taken}, 32'd1);
        chk_flags("brsf", 1'b0, 1'b0, 1'b0);

        // ---- stall for 3 cycles after a taken AL branch ----
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b111;
        bus.ex_br_target = 16'h0200;
        bus.alu_result   = 16'h00AA;
        bus.ex_wr_en     = 1'b1;
        bus.ex_wr_reg    = 3'd2;
        tick();
        chk("stl.pre_taken", {31'd0, bus.br_taken}, 32'd1);
        idle();
        bus.stall        = 1'b1;
        bus.ex_valid     = 1'b1;
        bus.ex_set_flags = 1'b1;
        bus.alu_z        = 1'b1;
        bus.alu_n        = 1'b1;
        bus.alu_result   = 16'h5555;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b111;
        bus.ex_br_target = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl.br_taken",   {31'd0, bus.br_taken}, 32'd0);
            chk("stl.mem_result", {16'd0, bus.mem_result}, 32'h00AA);
            chk("stl.ctrl",       {27'd0, bus.mem_valid, bus.mem_wr_en, bus.mem_wr_reg},
                                  {27'd0, 1'b1, 1'b1, 3'd2});
            chk("stl.br_target",  {16'd0, bus.br_target}, 32'h0200);
            chk_flags("stl", 1'b0, 1'b0, 1'b0);
        end

        // ---- bubble: ex_valid=0 with control inputs high ----
        idle();
        bus.ex_wr_en     = 1'b1;
        bus.ex_mem_rd    = 1'b1;
        bus.ex_mem_wr    = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b111;
        bus.ex_set_flags = 1'b1;
        bus.alu_z        = 1'b1;
        bus.alu_result   = 16'h7777;
        tick();
        chk("bub.ctrl",       {28'd0, bus.mem_valid, bus.mem_wr_en, bus.mem_rd, bus.mem_wr}, 32'd0);
        chk("bub.br_taken",   {31'd0, bus.br_taken}, 32'd0);
        chk("bub.mem_result", {16'd0, bus.mem_result}, 32'h7777);
        chk_flags("bub", 1'b0, 1'b0, 1'b0);

        // ---- flush together with stall ----
        idle();
        bus.stall        = 1'b1;
        bus.flush        = 1'b1;
        bus.ex_valid     = 1'b1;
        bus.ex_set_flags = 1'b1;
        bus.alu_z        = 1'b1;
        bus.alu_v        = 1'b1;
        bus.alu_n        = 1'b1;
        bus.alu_result   = 16'h3333;
        bus.ex_mem_rd    = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b111;
        bus.ex_br_target = 16'h0400;
        tick();
        chk("fl.mem_valid",  {31'd0, bus.mem_valid}, 32'd0);
        chk("fl.mem_rd",     {31'd0, bus.mem_rd}, 32'd0);
        chk("fl.br_taken",   {31'd0, bus.br_taken}, 32'd0);
        chk("fl.mem_result", {16'd0, bus.mem_result}, 32'd0);
        chk("fl.br_target",  {16'd0, bus.br_target}, 32'd0);
        chk_flags("fl", 1'b0, 1'b0, 1'b0);

        // ---- reset right after a taken branch ----
        idle();
        bus.ex_valid     = 1'b1;
        bus.ex_br        = 1'b1;
        bus.ex_br_cond   = 3'b111;
        bus.ex_br_target = 16'h0500;
        bus.ex_set_flags = 1'b1;
        bus.alu_v        = 1'b1;
        bus.alu_result   = 16'h0042;
        bus.ex_wr_en     = 1'b1;
        tick();
        chk("rb.pre_taken", {31'd0, bus.br_taken}, 32'd1);
        chk_flags("rb.pre", 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk("rb.br_taken",   {31'd0, bus.br_taken}, 32'd0);
        chk("rb.br_target",  {16'd0, bus.br_target}, 32'd0);
        chk("rb.mem_result", {16'd0, bus.mem_result}, 32'd0);
        chk("rb.ctrl",       {29'd0, bus.mem_valid, bus.mem_wr_en, bus.mem_rd}, 32'd0);
        chk_flags("rb", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
